// File: rtl/hilo_muldiv_unit.sv
// HI/LO multiply/divide unit for the E stage: result is formed at Start, held pending,
// and committed to HI/LO after a fixed busy latency. Optional accumulate: MULDIV_MADD_EN.
module hilo_muldiv_unit #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [1:0]  Type,
  input  logic        Start,
  input  logic [1:0]  Write,
  input  logic        Acc,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        Busy
);

  localparam int MAX_CYCLES = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d;
  logic [31:0]        ph_q, ph_d, pl_q, pl_d;
  logic               commit_q, commit_d;

  logic [63:0] op_a_ext, op_b_ext, product, product_acc, result;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_div, q_mag, r_mag, quot, rem;

  // Datapath: one shared signed/unsigned path, Type[0] selects unsigned.
  always_comb begin
    op_a_ext = Type[0] ? {32'b0, A} : {{32{A[31]}}, A};
    op_b_ext = Type[0] ? {32'b0, B} : {{32{B[31]}}, B};
    product  = op_a_ext * op_b_ext;
`ifdef MULDIV_MADD_EN
    product_acc = Acc ? ({hi_q, lo_q} + product) : product;
`else
    product_acc = product;
`endif
    // Divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000 without overflow.
    a_neg  = ~Type[0] & A[31];
    b_neg  = ~Type[0] & B[31];
    a_mag  = a_neg ? -A : A;
    b_mag  = b_neg ? -B : B;
    b_div  = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag  = a_mag / b_div;
    r_mag  = a_mag % b_div;
    quot   = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem    = a_neg ? -r_mag : r_mag;
    result = Type[1] ? {rem, quot} : product_acc;
  end

  always_comb begin
    // NOTE: every next-state value gets its hold default first so no path infers a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    ph_d     = ph_q;
    pl_d     = pl_q;
    commit_d = commit_q;
    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          {ph_d, pl_d} = result;
          commit_d     = !(Type[1] && (B == 32'd0));
          cnt_d        = Type[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
          state_d      = S_BUSY;
        end else if (Write == 2'b01) begin
          hi_d = A;
        end else if (Write == 2'b10) begin
          lo_d = A;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          if (commit_q) begin
            hi_d = ph_q;
            lo_d = pl_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignment so all registers update together.
    if (Reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      ph_q     <= '0;
      pl_q     <= '0;
      commit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      ph_q     <= ph_d;
      pl_q     <= pl_d;
      commit_q <= commit_d;
    end
  end

  assign HI   = hi_q;
  assign LO   = lo_q;
  assign Busy = (state_q == S_BUSY);

`ifndef MULDIV_MADD_EN
  logic unused_acc;
  assign unused_acc = Acc;
`endif

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: per-cycle compare against an arithmetic
// model plus directed literal expectations. Honors MULDIV_MADD_EN when defined.
module tb_hilo_muldiv_unit;

  localparam int MUL_N = 5;
  localparam int DIV_N = 10;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] A = '0, B = '0;
  logic [1:0]  Type = '0, Write = '0;
  logic        Start = 1'b0, Acc = 1'b0;
  logic [31:0] HI, LO;
  logic        Busy;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  hilo_muldiv_unit #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .Clk(Clk), .Reset(Reset), .A(A), .B(B), .Type(Type), .Start(Start),
    .Write(Write), .Acc(Acc), .HI(HI), .LO(LO), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural model: HI/LO plus the remaining busy time of the op in flight.
  logic [31:0] m_hi = '0, m_lo = '0, m_ph = '0, m_pl = '0;
  bit          m_act = 1'b0, m_commit = 1'b0;
  int          m_left = 0;

  function automatic void model_op(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b,
                                   input logic acc, input logic [31:0] hi, input logic [31:0] lo,
                                   output logic [63:0] res, output bit commit);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    commit = 1'b1;
    res = '0;
    case (t)
      2'b00: res = 64'(sa * sb);
      2'b01: res = ua * ub;
      2'b10: if (b == 0) commit = 1'b0;
             else begin q = sa / sb; r = sa % sb; res = {r[31:0], q[31:0]}; end
      default: if (b == 0) commit = 1'b0;
               else res = {32'(ua % ub), 32'(ua / ub)};
    endcase
`ifdef MULDIV_MADD_EN
    if (acc && !t[1]) res = res + {hi, lo};
`endif
  endfunction

  always @(posedge Clk) begin
    logic [63:0] res;
    bit          cm;
    if (Reset) begin
      m_hi <= '0; m_lo <= '0; m_act <= 1'b0; m_left <= 0;
    end else if (m_act) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_act <= 1'b0;
        if (m_commit) begin m_hi <= m_ph; m_lo <= m_pl; end
      end
    end else if (Start) begin
      model_op(Type, A, B, Acc, m_hi, m_lo, res, cm);
      {m_ph, m_pl} <= res;
      m_commit <= cm;
      m_act    <= 1'b1;
      m_left   <= Type[1] ? DIV_N : MUL_N;
    end else if (Write == 2'b01) begin
      m_hi <= A;
    end else if (Write == 2'b10) begin
      m_lo <= A;
    end
  end

  always @(negedge Clk) begin
    if (cmp_en) begin
      check("cyc_hi", HI, m_hi);
      check("cyc_lo", LO, m_lo);
      check("cyc_busy", {31'b0, Busy}, {31'b0, m_act});
      assert (!(Start && Busy)) else $error("Start issued while Busy");
    end
  end

  task automatic issue(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b,
                       input logic acc);
    Type = t; A = a; B = b; Acc = acc; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0; Acc = 1'b0;
  endtask

  // Called in cycle T+1; returns the number of consecutive Busy cycles observed.
  task automatic wait_idle(output int n);
    n = 0;
    while (Busy && n < DIV_N + 4) begin
      n++;
      @(negedge Clk);
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] t, input logic [31:0] a,
                        input logic [31:0] b, input logic acc,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input int exp_n);
    int n;
    issue(t, a, b, acc);
    wait_idle(n);
    check({name, "_busy_cycles"}, 32'(n), 32'(exp_n));
    check({name, "_hi"}, HI, exp_hi);
    check({name, "_lo"}, LO, exp_lo);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    cmp_en = 1'b1;
    repeat (3) begin
      check("reset_hi", HI, 32'h0);
      check("reset_lo", LO, 32'h0);
      check("reset_busy", {31'b0, Busy}, 32'h0);
      @(negedge Clk);
    end

    run_op("mult",  2'b00, 32'hFFFF_FFFF, 32'd2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_N);
    run_op("multu", 2'b01, 32'hFFFF_FFFF, 32'd2, 1'b0, 32'h0000_0001, 32'hFFFF_FFFE, MUL_N);
    run_op("div",   2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_N);
    run_op("divu0", 2'b11, 32'd1234,      32'd0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_N);
    run_op("divov", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h8000_0000, DIV_N);
    run_op("divu",  2'b11, 32'd100,       32'd7, 1'b0, 32'd2, 32'd14, DIV_N);

    Write = 2'b01; A = 32'h1234;
    @(negedge Clk);
    Write = 2'b00;
    check("mthi", HI, 32'h1234);
    Write = 2'b10; A = 32'h5678;
    @(negedge Clk);
    Write = 2'b11; A = 32'hAAAA_AAAA;
    check("mtlo", LO, 32'h5678);
    @(negedge Clk);
    Write = 2'b00;
    check("wr_rsvd_hi", HI, 32'h1234);
    check("wr_rsvd_lo", LO, 32'h5678);

    issue(2'b00, 32'd3, 32'd4, 1'b0);
    Write = 2'b10; A = 32'hDEAD;
    @(negedge Clk);
    Write = 2'b00;
    wait_idle(n);
    check("mtlo_busy_lo", LO, 32'd12);
    check("mtlo_busy_hi", HI, 32'd0);

    Write = 2'b01;
    run_op("start_wins", 2'b01, 32'd2, 32'd3, 1'b0, 32'd0, 32'd6, MUL_N);
    Write = 2'b00;

    issue(2'b00, 32'd5, 32'd6, 1'b0);
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    check("rst_mid_busy", {31'b0, Busy}, 32'h0);
    check("rst_mid_hi", HI, 32'h0);
    check("rst_mid_lo", LO, 32'h0);
    repeat (8) @(negedge Clk);
    check("rst_mid_nocommit", LO, 32'h0);

    Write = 2'b10; A = 32'hFFFF_FFFF;
    @(negedge Clk);
    Write = 2'b00;
`ifdef MULDIV_MADD_EN
    run_op("maddu", 2'b01, 32'd1, 32'd1, 1'b1, 32'd1, 32'd0, MUL_N);
    run_op("madd",  2'b00, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'd0, 32'hFFFF_FFFF, MUL_N);
`else
    run_op("acc_ignored", 2'b01, 32'd1, 32'd1, 1'b1, 32'd0, 32'd1, MUL_N);
`endif

    repeat (3) @(negedge Clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
